// File: rtl/id_operand_stage.sv
// Operand collection with EXE/MEM/WB bypass, load-use stall detection
// and the ID/EXE pipeline register.
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_wn,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic [3:0]        id_aluc,
    input  logic              id_aluimm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rf_qa,
    input  logic [DATA_W-1:0] rf_qb,
    input  logic [DATA_W-1:0] exe_alu,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wn,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_mdo,
    input  logic              wb_wreg,
    input  logic [REG_AW-1:0] wb_wn,
    input  logic [DATA_W-1:0] wb_d,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_wreg,
    output logic [REG_AW-1:0] ex_wn,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic [3:0]        ex_aluc,
    output logic              ex_aluimm
);

    logic              exe_fwd;
    logic [DATA_W-1:0] mem_val;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              hz_rs;
    logic              hz_rt;
    logic              bubble;

    // A load in EXE has no data yet, so it never forwards from exe_alu.
    assign exe_fwd = ex_valid & ex_wreg & ~ex_m2reg;
    assign mem_val = mem_m2reg ? mem_mdo : mem_alu;

    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] rn,
        input logic [DATA_W-1:0] rf
    );
        logic [DATA_W-1:0] v;
        if (rn == '0)
            v = '0;
        else if (exe_fwd && ex_wn == rn)
            v = exe_alu;
        else if (mem_wreg && mem_wn == rn)
            v = mem_val;
        else if (wb_wreg && wb_wn == rn)
            v = wb_d;
        else
            v = rf;
        return v;
    endfunction

    always_comb begin
        opa = resolve(id_rs, rf_qa);
        opb = resolve(id_rt, rf_qb);
    end

    assign hz_rs = id_use_rs & (id_rs == ex_wn);
    assign hz_rt = id_use_rt & (id_rt == ex_wn);

    assign stall = id_valid & ~flush & ex_valid & ex_wreg & ex_m2reg
                 & (ex_wn != '0) & (hz_rs | hz_rt);

    assign bubble = flush | stall | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_wreg   <= 1'b0;
            ex_wn     <= '0;
            ex_m2reg  <= 1'b0;
            ex_wmem   <= 1'b0;
            ex_aluc   <= '0;
            ex_aluimm <= 1'b0;
        end else if (bubble) begin
            ex_valid  <= 1'b0;
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            ex_wmem   <= 1'b0;
        end else begin
            ex_valid  <= 1'b1;
            ex_a      <= opa;
            ex_b      <= opb;
            ex_imm    <= id_imm;
            ex_wreg   <= id_wreg;
            ex_wn     <= id_wn;
            ex_m2reg  <= id_m2reg;
            ex_wmem   <= id_wmem;
            ex_aluc   <= id_aluc;
            ex_aluimm <= id_aluimm;
        end
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Operand-collection stage plus ID/EXE pipeline register for the tiny MIPS pipeline.
- Takes combinational register-file read data for rs/rt and resolves data hazards by bypassing from EXE, MEM and WB.
- Detects load-use hazards, raising a stall and inserting a bubble.
- Latches resolved operands and control into the EXE stage each cycle.

Parameters:
DATA_W, 32, datapath/register width
REG_AW, 5, register-number width (32 registers, r0 hardwired zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  REG_AW  source A register number (also drives regfile read port A)
id_rt  in  REG_AW  source B register number (also drives regfile read port B)
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_wreg  in  1  instruction writes a register
id_wn  in  REG_AW  destination register
id_m2reg  in  1  instruction is a load
id_wmem  in  1  instruction is a store
id_aluc  in  4  ALU opcode
id_aluimm  in  1  ALU B takes immediate
id_imm  in  DATA_W  extended immediate
rf_qa  in  DATA_W  regfile read data A
rf_qb  in  DATA_W  regfile read data B
exe_alu  in  DATA_W  combinational ALU result of the instruction now in EXE
mem_wreg  in  1  MEM instruction writes a register
mem_wn  in  REG_AW  MEM destination
mem_m2reg  in  1  MEM instruction is a load
mem_alu  in  DATA_W  MEM-stage ALU result
mem_mdo  in  DATA_W  MEM-stage load data
wb_wreg  in  1  WB write enable (same signal as regfile we)
wb_wn  in  REG_AW  WB destination
wb_d  in  DATA_W  WB write data
flush  in  1  discard the instruction in ID (branch redirect)
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EXE slot holds a real instruction
ex_a  out  DATA_W  resolved rs operand
ex_b  out  DATA_W  resolved rt operand (ALU B or store data)
ex_imm  out  DATA_W  registered immediate
ex_wreg, ex_wn, ex_m2reg, ex_wmem, ex_aluc, ex_aluimm  out  1/REG_AW/1/1/4/1  registered control

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. During reset all ex_* outputs = 0 and ex_valid = 0. stall is combinational and is 0 whenever ex_valid = 0.
- Each operand is resolved independently. For rs, the first match wins:
  - rs == 0 -> 0.
  - EXE hit (ex_valid & ex_wreg & ex_wn == rs & !ex_m2reg) -> exe_alu.
  - MEM hit (mem_wreg & mem_wn == rs) -> mem_m2reg ? mem_mdo : mem_alu.
  - WB hit (wb_wreg & wb_wn == rs) -> wb_d. This covers the same-cycle regfile write, which is not yet visible on rf_qa.
  - Otherwise -> rf_qa.
- rt uses the same priority with rf_qb.
- Forwarding applies even when id_use_* = 0; the value is don't-care but must be deterministic.
- Load-use stall = id_valid & !flush & ex_valid & ex_wreg & ex_m2reg & ex_wn != 0 & ((id_use_rs & id_rs == ex_wn) | (id_use_rt & id_rt == ex_wn)).
- A hazard against r0 never stalls.
- Pipeline register, on each rising edge:
  - flush | stall | !id_valid -> bubble: ex_valid, ex_wreg, ex_wmem, ex_m2reg <= 0. Other ex_* fields are don't-care and may retain their values.
  - Otherwise: ex_valid <= 1; ex_a and ex_b <= resolved operands; all control and ex_imm latch from id_*.
- Stall lasts exactly one cycle per load-use hazard. After the bubble, the load sits in MEM and the dependent instruction is satisfied through the MEM mem_mdo path.
- flush has priority over stall: stall is forced to 0 and a bubble is inserted.
- A reset asserted mid-stall clears ex_valid; stall deasserts immediately.
- Latency: ID to ex_* is 1 cycle. No internal state beyond the ID/EXE register.

Test Plan:
1. Reset release with id_valid=0 -> ex_valid=0, stall=0 and all ex_* = 0 for 3 cycles.
2. ADD r3 in EXE (exe_alu=0x11) and MEM also writing r3 (mem_alu=0x22); ID reads rs=r3 -> ex_a=0x11 next cycle. Remove the EXE hit -> ex_a=0x22.
3. WB writes r5=0xDEAD while rf_qb still shows 0x0; ID reads rt=r5 -> ex_b=0xDEAD.
4. LW r4 in EXE; ID uses rs=r4 -> stall=1 for one cycle and ex_valid=0 bubble. Next cycle mem_mdo=0xCAFE gives ex_a=0xCAFE and stall=0.
5. LW r0 in EXE; ID uses rs=r0 -> stall=0, ex_a=0. Separately, EXE writes r0 with exe_alu=0x7 -> ex_a=0.
6. Load-use hazard with flush=1 in the same cycle -> stall=0 and a bubble is inserted. Also assert rst_n=0 during a stall cycle -> ex_valid=0 and stall=0 immediately.
